// File: rtl/scan_decoder_n.sv
// scan_decoder_n: registered N-to-2^N line decoder with direct and scan modes.
// In direct mode the selected line follows the last loaded address. In scan
// mode the selected line steps through 0..scan_last and holds each line for
// DWELL cycles. o_out is decoded from the next-state address on the same edge
// that updates o_cur_addr, so the two outputs always change together.
module scan_decoder_n #(
  parameter int ADDR_W     = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int DWELL      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_mode,
  input  logic                   i_load,
  input  logic [ADDR_W-1:0]      i_addr_in,
  input  logic [ADDR_W-1:0]      i_scan_last,
  output logic [(2**ADDR_W)-1:0] o_out,
  output logic [ADDR_W-1:0]      o_cur_addr,
  output logic                   o_wrap
);

  localparam int OUT_W = 2 ** ADDR_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [OUT_W-1:0]  LINE0    = OUT_W'(1);
  localparam logic [OUT_W-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [ADDR_W-1:0] r_curAddr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_prevMode;
  logic              r_wrap;
  logic [OUT_W-1:0]  r_out;

  logic [ADDR_W-1:0] w_nextAddr;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              w_nextWrap;
  logic [OUT_W-1:0]  w_oneHot;
  logic [OUT_W-1:0]  w_decoded;

  // Next address/counter/wrap for an enabled edge: load beats a mode change,
  // which beats a scan step. Advancing past scan_last (or any address above a
  // freshly lowered scan_last) wraps back to line 0.
  always_comb begin
    w_nextAddr = r_curAddr;
    w_nextCnt  = r_cnt;
    w_nextWrap = 1'b0;
    if (i_load) begin
      w_nextAddr = i_addr_in;
      w_nextCnt  = '0;
    end else if (i_mode != r_prevMode) begin
      w_nextCnt = '0;
    end else if (!i_mode) begin
      w_nextCnt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_nextCnt = '0;
      if (r_curAddr >= i_scan_last) begin
        w_nextAddr = '0;
        w_nextWrap = 1'b1;
      end else begin
        w_nextAddr = r_curAddr + ADDR_ONE;
      end
    end else begin
      w_nextCnt = r_cnt + CNT_ONE;
    end
  end

  // Decode the next-state address into one-hot or one-cold line selects.
  always_comb begin
    w_oneHot  = LINE0 << w_nextAddr;
    w_decoded = (ACTIVE_LOW != 0) ? ~w_oneHot : w_oneHot;
  end

  // State and output registers; a disabled edge blanks the outputs and
  // freezes the address, dwell counter and mode tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_curAddr  <= '0;
      r_cnt      <= '0;
      r_prevMode <= 1'b0;
      r_wrap     <= 1'b0;
      r_out      <= INACTIVE;
    end else if (i_en) begin
      r_curAddr  <= w_nextAddr;
      r_cnt      <= w_nextCnt;
      r_prevMode <= i_mode;
      r_wrap     <= w_nextWrap;
      r_out      <= w_decoded;
    end else begin
      r_wrap <= 1'b0;
      r_out  <= INACTIVE;
    end
  end

  assign o_out      = r_out;
  assign o_cur_addr = r_curAddr;
  assign o_wrap     = r_wrap;

endmodule

// File: tb/tb_scan_decoder_n.sv
// tb_scan_decoder_n: checks two decoder configurations (3-bit active-low with
// DWELL=4, and 4-bit active-high with DWELL=1) against a behavioural model,
// a table of direct-mode vectors and hand-written multi-cycle sequences.
module tb_scan_decoder_n;

  typedef struct {
    int addr;
    int phase;
    int prevMode;
    int wrap;
    int active;
  } model_t;

  typedef struct {
    bit         en;
    bit         mode;
    bit         load;
    logic [2:0] addr;
    logic [7:0] expOut;
    logic [2:0] expAddr;
    bit         expWrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       aEn = 0, aMode = 0, aLoad = 0;
  logic [2:0] aAddr = 0, aLast = 0;
  logic [7:0] aOut;
  logic [2:0] aCur;
  logic       aWrap;

  logic       bEn = 0, bMode = 0, bLoad = 0;
  logic [3:0] bAddr = 0, bLast = 0;
  logic [15:0] bOut;
  logic [3:0]  bCur;
  logic        bWrap;

  model_t mA, mB;
  int checks = 0;
  int errors = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  scan_decoder_n #(.ADDR_W(3), .ACTIVE_LOW(1), .DWELL(4)) dutA (
    .i_clk(clk), .i_rst(rst), .i_en(aEn), .i_mode(aMode), .i_load(aLoad),
    .i_addr_in(aAddr), .i_scan_last(aLast),
    .o_out(aOut), .o_cur_addr(aCur), .o_wrap(aWrap)
  );

  scan_decoder_n #(.ADDR_W(4), .ACTIVE_LOW(0), .DWELL(1)) dutB (
    .i_clk(clk), .i_rst(rst), .i_en(bEn), .i_mode(bMode), .i_load(bLoad),
    .i_addr_in(bAddr), .i_scan_last(bLast),
    .o_out(bOut), .o_cur_addr(bCur), .o_wrap(bWrap)
  );

  // One enabled/disabled edge of the behavioural decoder: phase counts modulo
  // dwell in scan mode and the address moves whenever the phase rolls over.
  function automatic model_t modelStep(model_t s, bit en, bit mode, bit load,
                                       int addrIn, int scanLast, int dwell);
    model_t n = s;
    n.wrap = 0;
    if (!en) begin
      n.active = 0;
      return n;
    end
    n.active = 1;
    if (load) begin
      n.addr  = addrIn;
      n.phase = 0;
    end else if (int'(mode) != s.prevMode) begin
      n.phase = 0;
    end else if (mode) begin
      n.phase = (s.phase + 1) % dwell;
      if (n.phase == 0) begin
        if (s.addr >= scanLast) begin
          n.addr = 0;
          n.wrap = 1;
        end else begin
          n.addr = s.addr + 1;
        end
      end
    end
    n.prevMode = int'(mode);
    return n;
  endfunction

  function automatic model_t modelReset();
    model_t r;
    r.addr = 0; r.phase = 0; r.prevMode = 0; r.wrap = 0; r.active = 0;
    return r;
  endfunction

  function automatic logic [7:0] expA(model_t s);
    logic [7:0] v;
    v = 8'hFF;
    if (s.active != 0) v[s.addr] = 1'b0;
    return v;
  endfunction

  function automatic logic [15:0] expB(model_t s);
    logic [15:0] v;
    v = 16'h0000;
    if (s.active != 0) v[s.addr] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit mode, input bit load,
                               input logic [2:0] addr, input logic [2:0] last);
    aEn = en; aMode = mode; aLoad = load; aAddr = addr; aLast = last;
  endtask

  task automatic applyB(input bit en, input bit mode, input bit load,
                        input logic [3:0] addr, input logic [3:0] last);
    bEn = en; bMode = mode; bLoad = load; bAddr = addr; bLast = last;
  endtask

  task automatic checkModels();
    checkOutput("A.out",  32'(aOut),  32'(expA(mA)));
    checkOutput("A.addr", 32'(aCur),  32'(mA.addr));
    checkOutput("A.wrap", 32'(aWrap), 32'(mA.wrap));
    checkOutput("B.out",  32'(bOut),  32'(expB(mB)));
    checkOutput("B.addr", 32'(bCur),  32'(mB.addr));
    checkOutput("B.wrap", 32'(bWrap), 32'(mB.wrap));
  endtask

  task automatic tick();
    @(posedge clk);
    mA = modelStep(mA, aEn, aMode, aLoad, int'(aAddr), int'(aLast), 4);
    mB = modelStep(mB, bEn, bMode, bLoad, int'(bAddr), int'(bLast), 1);
    #1;
    checkModels();
  endtask

  task automatic pulseReset();
    #2 rst = 1'b1;
    #1;
    mA = modelReset();
    mB = modelReset();
    checkOutput("rst.A.out",  32'(aOut),  32'h0000_00FF);
    checkOutput("rst.A.addr", 32'(aCur),  32'h0);
    checkOutput("rst.A.wrap", 32'(aWrap), 32'h0);
    checkOutput("rst.B.out",  32'(bOut),  32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int wrapTick[$];
    mA = modelReset();
    mB = modelReset();

    vecs[0] = '{1'b1, 1'b0, 1'b1, 3'd5, 8'hDF, 3'd5, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 3'd1, 8'hDF, 3'd5, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'hDF, 3'd5, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd2, 8'hFF, 3'd5, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'hDF, 3'd5, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'd0, 8'hFE, 3'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 3'd7, 8'h7F, 3'd7, 1'b0};

    // Reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    checkOutput("init.A.out",  32'(aOut),  32'h0000_00FF);
    checkOutput("init.A.addr", 32'(aCur),  32'h0);
    checkOutput("init.A.wrap", 32'(aWrap), 32'h0);
    checkOutput("init.B.out",  32'(bOut),  32'h0);
    #1 rst = 1'b0;

    // Direct-mode table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].addr, 3'd7);
      tick();
      checkOutput($sformatf("vec%0d.out", i),  32'(aOut),  32'(vecs[i].expOut));
      checkOutput($sformatf("vec%0d.addr", i), 32'(aCur),  32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d.wrap", i), 32'(aWrap), 32'(vecs[i].expWrap));
    end

    // Full scan 0..7 with a 32-cycle period.
    pulseReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (aWrap === 1'b1) begin
        wrapTick.push_back(t);
        checkOutput("scan.wrapOut", 32'(aOut), 32'h0000_00FE);
      end
    end
    checkOutput("scan.wrapCount", 32'(wrapTick.size()), 32'd2);
    if (wrapTick.size() >= 2) begin
      checkOutput("scan.firstWrap", 32'(wrapTick[0]), 32'd33);
      checkOutput("scan.period", 32'(wrapTick[1] - wrapTick[0]), 32'd32);
    end

    // Lowering scan_last below the current address wraps at the next expiry.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd5, 3'd7);
    tick();
    checkOutput("lower.load", 32'(aCur), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 3'd2);
    for (int t = 0; t < 3; t++) begin
      tick();
      checkOutput("lower.hold", 32'(aCur), 32'd5);
    end
    tick();
    checkOutput("lower.addr", 32'(aCur),  32'd0);
    checkOutput("lower.wrap", 32'(aWrap), 32'd1);
    checkOutput("lower.out",  32'(aOut),  32'h0000_00FE);

    // Disable partway through line 3, then resume.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd3, 3'd7);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd7);
    for (int t = 0; t < 5; t++) begin
      tick();
      checkOutput("dis.out",  32'(aOut), 32'h0000_00FF);
      checkOutput("dis.addr", 32'(aCur), 32'd3);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
    tick();
    checkOutput("reen1.out", 32'(aOut), 32'h0000_00F7);
    tick();
    checkOutput("reen2.out", 32'(aOut), 32'h0000_00F7);
    tick();
    checkOutput("reen3.out", 32'(aOut), 32'h0000_00EF);
    checkOutput("reen3.addr", 32'(aCur), 32'd4);

    // Reset in the middle of a scan, then restart from line 0.
    for (int t = 0; t < 6; t++) tick();
    pulseReset();
    tick();
    checkOutput("rstScan.addr", 32'(aCur), 32'd0);
    checkOutput("rstScan.out",  32'(aOut), 32'h0000_00FE);

    // Wide active-high decoder: direct sweep of every address.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 3'd7);
    for (int i = 0; i < 16; i++) begin
      applyB(1'b1, 1'b0, 1'b1, 4'(i), 4'd15);
      tick();
      checkOutput($sformatf("sweep%0d.out", i), 32'(bOut), 32'(16'h1 << i));
      checkOutput($sformatf("sweep%0d.addr", i), 32'(bCur), 32'(i));
    end

    // DWELL=1 scan over the full range, then a load during scanning.
    applyB(1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
    tick();
    checkOutput("b.modeChg.addr", 32'(bCur), 32'd15);
    tick();
    checkOutput("b.wrap",      32'(bWrap), 32'd1);
    checkOutput("b.wrap.addr", 32'(bCur),  32'd0);
    tick();
    checkOutput("b.step.addr", 32'(bCur),  32'd1);
    applyB(1'b1, 1'b1, 1'b1, 4'd9, 4'd15);
    tick();
    checkOutput("b.loadWins.addr", 32'(bCur), 32'd9);
    checkOutput("b.loadWins.out",  32'(bOut), 32'h0000_0200);

    // Randomized traffic on both decoders against the model.
    for (int t = 0; t < 400; t++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    ($urandom_range(0, 19) == 0) ? ~aMode : aMode,
                    $urandom_range(0, 14) == 0,
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 7)) : aLast);
      applyB($urandom_range(0, 9) != 0,
             ($urandom_range(0, 19) == 0) ? ~bMode : bMode,
             $urandom_range(0, 14) == 0,
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 29) == 0) ? 4'($urandom_range(0, 15)) : bLast);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
